// File: rtl/reaction_timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// reaction_timer_ctrl_if
//
// Signal bundle between the reaction-timer sequencer and its surroundings:
// the debounced button pulses, the 13-bit reaction counter, and the
// display/LED consumers.
//
//   start        1   single-cycle pulse, begins a round
//   stop         1   single-cycle pulse, player reaction
//   count_in     13  current value of the reaction counter
//   cnt_go       1   counter synchronous clear
//   cnt_en       1   counter increment enable
//   led_ready    1   "react now" indicator
//   result       13  last captured time, or the timeout value
//   best         13  minimum valid result since reset
//   result_valid 1   last round completed normally
//   foul         1   last round ended by an early stop
//   timeout      1   last round was abandoned at the timeout value
//   state_out    3   current sequencer state (debug/display)
//
// master : the sequencer side (reaction_timer_ctrl)
// slave  : the environment side (buttons, counter, display)
// ---------------------------------------------------------------------------
interface reaction_timer_ctrl_if;
    logic        start;
    logic        stop;
    logic [12:0] count_in;
    logic        cnt_go;
    logic        cnt_en;
    logic        led_ready;
    logic [12:0] result;
    logic [12:0] best;
    logic        result_valid;
    logic        foul;
    logic        timeout;
    logic [2:0]  state_out;

    modport master (
        input  start, stop, count_in,
        output cnt_go, cnt_en, led_ready, result, best,
               result_valid, foul, timeout, state_out
    );

    modport slave (
        output start, stop, count_in,
        input  cnt_go, cnt_en, led_ready, result, best,
               result_valid, foul, timeout, state_out
    );
endinterface

// File: rtl/reaction_timer_ctrl.sv
// ---------------------------------------------------------------------------
// reaction_timer_ctrl
//
// Round sequencer for the reaction-timer game. Each round waits a
// pseudo-random pre-delay, then releases the external 13-bit count-up
// counter at one increment per time tick and captures its value when the
// player presses stop. Early presses (fouls), abandoned rounds (timeouts)
// and the best valid time since reset are tracked.
//
// Ports:
//   clk     system clock, all registers update on its rising edge
//   resetn  synchronous, active-low reset
//   bus     reaction_timer_ctrl_if.master
//             in : start, stop, count_in
//             out: cnt_go, cnt_en, led_ready, result, best,
//                  result_valid, foul, timeout, state_out
//
// Parameters:
//   TICK_DIV   clk cycles per time tick (50000 at 50 MHz gives 1 ms)
//   DELAY_MIN  minimum pre-delay in ticks
//   TIMEOUT    count at which a round is abandoned (must be below 8191)
// ---------------------------------------------------------------------------
module reaction_timer_ctrl #(
    parameter int TICK_DIV  = 50000,
    parameter int DELAY_MIN = 1000,
    parameter int TIMEOUT   = 5000
) (
    input  logic                  clk,
    input  logic                  resetn,
    reaction_timer_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_FOUL = 3'd4,
        S_TOUT = 3'd5
    } state_t;

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [12:0]     TIMEOUT_V  = 13'(TIMEOUT);
    localparam logic [11:0]     DELAY_MIN_V = 12'(DELAY_MIN);
    localparam logic [11:0]     LFSR_SEED  = 12'hACE;

    logic [PW-1:0] presc;
    logic          tick;
    logic [11:0]   lfsr;
    logic          lfsr_fb;
    logic [11:0]   delay;
    state_t        state;
    logic          cnt_go_q;
    logic          led_q;
    logic [12:0]   result_q;
    logic [12:0]   best_q;
    logic          valid_q;
    logic          foul_q;
    logic          tout_q;
    logic          below_timeout;

    // ---------------------------------------------------------------------
    // Tick prescaler: free-running, independent of the round state so tick
    // phase is not aligned to button presses.
    // ---------------------------------------------------------------------
    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Pre-delay randomiser: x^12 + x^11 + x^10 + x^4 + 1 is maximal length,
    // so a non-zero seed never reaches zero; the reload only guards against
    // an upset landing the register in the lock-up state.
    // ---------------------------------------------------------------------
    assign lfsr_fb = lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr <= LFSR_SEED;
        end else if (lfsr == '0) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[10:0], lfsr_fb};
        end
    end

    // ---------------------------------------------------------------------
    // Counter enable is combinational so that a stop arriving on a tick
    // cycle suppresses that increment and the captured value matches the
    // value shown on the display. The timeout compare also freezes the
    // counter at TIMEOUT for the one cycle before the state leaves RUN.
    // ---------------------------------------------------------------------
    assign below_timeout = (bus.count_in < TIMEOUT_V);
    assign bus.cnt_en    = tick & (state == S_RUN) & ~bus.stop & below_timeout;

    // ---------------------------------------------------------------------
    // Round sequencer with registered outputs. cnt_go/led_ready are set
    // alongside each transition so they reflect the state being entered.
    // The delay register is pure data: it is always loaded on entry to
    // WAIT before it is read, so it carries no reset.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt_go_q <= 1'b1;
            led_q    <= 1'b0;
            result_q <= '0;
            best_q   <= 13'h1FFF;
            valid_q  <= 1'b0;
            foul_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FOUL, S_TOUT: begin
                    // start beats a coincident stop here
                    if (bus.start) begin
                        state    <= S_WAIT;
                        cnt_go_q <= 1'b1;
                        led_q    <= 1'b0;
                        delay    <= DELAY_MIN_V + {1'b0, lfsr[10:0]};
                        valid_q  <= 1'b0;
                        foul_q   <= 1'b0;
                        tout_q   <= 1'b0;
                    end
                end

                S_WAIT: begin
                    if (bus.stop) begin
                        state    <= S_FOUL;
                        cnt_go_q <= 1'b0;
                        led_q    <= 1'b0;
                        foul_q   <= 1'b1;
                    end else if (tick) begin
                        // delay==0 on entry is treated as already expired
                        if (delay <= 12'd1) begin
                            state    <= S_RUN;
                            cnt_go_q <= 1'b0;
                            led_q    <= 1'b1;
                        end else begin
                            delay <= delay - 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (bus.stop) begin
                        state    <= S_DONE;
                        cnt_go_q <= 1'b0;
                        led_q    <= 1'b0;
                        result_q <= bus.count_in;
                        valid_q  <= 1'b1;
                        if (bus.count_in < best_q) begin
                            best_q <= bus.count_in;
                        end
                    end else if (!below_timeout) begin
                        state    <= S_TOUT;
                        cnt_go_q <= 1'b0;
                        led_q    <= 1'b0;
                        result_q <= TIMEOUT_V;
                        tout_q   <= 1'b1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    cnt_go_q <= 1'b1;
                    led_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cnt_go       = cnt_go_q;
    assign bus.led_ready    = led_q;
    assign bus.result       = result_q;
    assign bus.best         = best_q;
    assign bus.result_valid = valid_q;
    assign bus.foul         = foul_q;
    assign bus.timeout      = tout_q;
    assign bus.state_out    = state;

endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
- Sequencer for the 13-bit count-up counter (go = synchronous clear, en = count enable) used as the game's reaction timer.
- Runs each round: random pre-delay, arms the counter at a 1 kHz tick, and captures the count when the player presses stop.
- Tracks fouls (early press), timeouts and the best time.
- Sits between the debounced/edge-detected buttons and the counter instance; its outputs feed the hex display and LED logic.

Parameters:
- TICK_DIV, 50000, clk cycles per time tick (50 MHz gives 1 ms).
- DELAY_MIN, 1000, minimum pre-delay in ticks.
- TIMEOUT, 5000, count value at which a round is abandoned; must be < 8191.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; one clock; synchronous, active-low.
- start  in  1  single-cycle pulse, begins a round.
- stop  in  1  single-cycle pulse, player reaction.
- count_in  in  13  current counter value.
- cnt_go  out  1  counter synchronous clear.
- cnt_en  out  1  counter increment enable.
- led_ready  out  1  "react now" indicator.
- result  out  13  last captured time or TIMEOUT.
- best  out  13  minimum valid result since reset.
- result_valid  out  1  last round completed normally.
- foul  out  1  last round ended by early stop.
- timeout  out  1  last round hit TIMEOUT.
- state_out  out  3  current FSM state, for debug/display.

Behaviour:
- All registers update on posedge clk.
- When resetn=0 at an edge:
  - state=IDLE, cnt_go=1, cnt_en=0, led_ready=0.
  - result=0, best=13'h1FFF, result_valid=0, foul=0, timeout=0.
  - Prescaler=0, LFSR=12'hACE.
- Prescaler: free-running 0..TICK_DIV-1; tick=1 for one clk when it wraps. It is not cleared by state changes.
- LFSR:
  - 12-bit Fibonacci, taps 12,11,10,4, shifts every clk.
  - Never reaches all-zero.
- State encoding: IDLE=0, WAIT=1, RUN=2, DONE=3, FOUL=4, TOUT=5. Remaining codes recover to IDLE on the next clk.
- Registered outputs: cnt_go=1 in IDLE/WAIT, else 0. led_ready=1 only in RUN.
- cnt_en is combinational: cnt_en = tick & (state==RUN) & ~stop & (count_in < TIMEOUT).
- IDLE, DONE, FOUL, TOUT on start:
  - go to WAIT.
  - Load delay = DELAY_MIN + lfsr[10:0], i.e. 1000..3047 ticks.
  - Clear result_valid, foul, timeout. result and best hold.
- WAIT:
  - Delay decrements on each tick.
  - stop -> FOUL, foul=1. This takes priority over delay expiry in the same cycle.
  - On the tick where delay==1 (or delay==0 on entry) -> RUN. Counter leaves clear the next cycle, so the first count increment is on the first tick seen in RUN.
  - start is ignored.
- RUN:
  - stop -> DONE.
    - result <= count_in; result_valid=1.
    - best <= min(best, count_in), same edge.
    - A stop coincident with tick suppresses that increment, so result equals the value on display.
  - Otherwise, count_in >= TIMEOUT -> TOUT; result <= TIMEOUT; timeout=1; best unchanged.
  - stop and timeout in the same cycle: stop wins.
  - start is ignored.
- DONE/FOUL/TOUT: flags and result hold; the counter is frozen (go=0, en=0) until the next start.
- start and stop in the same cycle: start wins in IDLE/DONE/FOUL/TOUT; stop wins in WAIT/RUN.
- resetn low mid-round: everything returns to reset values at that edge, including best and the LFSR. The counter is cleared via cnt_go=1 on the following cycle.
- Widths: all counts are 13-bit unsigned compares; the delay counter is 12 bits; no wrap is possible within TIMEOUT.

Test Plan:
Bench parameters: TICK_DIV=4, DELAY_MIN=3, TIMEOUT=20; the bench instantiates the real counter.
- Reset: hold resetn=0 for 2 clks -> state_out=0, cnt_go=1, cnt_en=0, best=1FFF, result=0, all flags 0.
- Normal round: start, wait for led_ready, then stop after 10 ticks -> state_out=3, result=10, result_valid=1, best=10, led_ready=0. count_in stays 10 for 50 clks.
- Best tracking: rounds with 7 then 12 ticks -> best=7 after both; result=12 after the last.
- Foul: start, then stop 1 tick later (before led_ready) -> state_out=4, foul=1, result unchanged, count_in=0, led_ready never 1.
- Timeout: start, no stop -> count_in reaches 20, state_out=5, timeout=1, result=20, best unchanged, count_in holds 20.
- Corner cases:
  - stop on a tick cycle at count 5 -> result=5 and count_in=5.
  - start+stop together in DONE -> WAIT.
  - resetn=0 mid-RUN -> IDLE, best=1FFF, count_in=0 the next cycle.
